// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch slice.
// Optional feature macro: PC_MISALIGN_CHECK_EN (enables the FAULT state and fetch_misalign).
package pc_fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Low PC bits that must be zero for a legal instruction address
  localparam logic [1:0]  INST_ALIGN_MASK  = 2'b11;

  localparam int unsigned STATE_W  = 3;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_REQ   = 3'd1;
  localparam logic [2:0]  ST_WAIT  = 3'd2;
  localparam logic [2:0]  ST_HOLD  = 3'd3;
  localparam logic [2:0]  ST_FAULT = 3'd4;

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC select: redirect target (alignment-handled) or sequential fetch_pc + 4.
// Optional feature macro: PC_MISALIGN_CHECK_EN (reports misaligned redirects instead of masking).
module pc_next_sel #(
  parameter int unsigned XLEN = pc_fetch_pkg::XLEN
) (
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc_c
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic            misalign_c
`endif
);
  import pc_fetch_pkg::*;

  logic [XLEN-1:0] target_c;

  // Redirect has priority over the sequential path
  always_comb begin
    target_c = redirect_pc;
`ifndef PC_MISALIGN_CHECK_EN
    target_c[1:0] = redirect_pc[1:0] & ~INST_ALIGN_MASK;
`endif
    next_pc_c = redirect_valid ? target_c : fetch_pc + XLEN'(4);
  end

`ifdef PC_MISALIGN_CHECK_EN
  // A misaligned redirect is flagged; the top refuses to fetch from it
  assign misalign_c = redirect_valid && (|(redirect_pc[1:0] & INST_ALIGN_MASK));
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetch sequencer (one outstanding request).
// Optional feature macro: PC_MISALIGN_CHECK_EN (misaligned redirect -> sticky FAULT).
module pc_fetch_unit #(
  parameter int unsigned      XLEN     = pc_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(pc_fetch_pkg::DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_misalign
);
  import pc_fetch_pkg::*;

  logic [STATE_W-1:0] state, state_nxt;
  logic [XLEN-1:0]    pc, pc_nxt;
  logic [XLEN-1:0]    inst_nxt, inst_pc_nxt;
  logic               kill, kill_nxt;
  logic               inst_valid_nxt;
  logic [XLEN-1:0]    next_pc_c;
  logic               req_fire_c;
`ifdef PC_MISALIGN_CHECK_EN
  logic               misalign_c;
  logic               misalign_nxt;
`endif

  pc_next_sel #(.XLEN(XLEN)) u_next_sel (
    .fetch_pc       (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc_c      (next_pc_c)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign_c     (misalign_c)
`endif
  );

  // Request is suppressed while decode is stalled on a presented instruction
  assign imem_req_valid = (state == ST_REQ) && !(inst_valid && stall);
  assign imem_req_addr  = pc;
  assign req_fire_c     = imem_req_valid && imem_req_ready;
  assign pc_plus4       = inst_pc + XLEN'(4);

  // Next-state and datapath decisions
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    kill_nxt       = kill;
    inst_valid_nxt = inst_valid;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
`ifdef PC_MISALIGN_CHECK_EN
    misalign_nxt   = fetch_misalign;
`endif

    if (inst_valid && !stall) inst_valid_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
        if (redirect_valid) pc_nxt = next_pc_c;
      end
      ST_REQ: begin
        if (req_fire_c) begin
          state_nxt = ST_WAIT;
          if (redirect_valid) begin
            kill_nxt = 1'b1;
            pc_nxt   = next_pc_c;
          end
        end else begin
          if (inst_valid && stall) state_nxt = ST_HOLD;
          if (redirect_valid) begin
            state_nxt      = ST_REQ;
            pc_nxt         = next_pc_c;
            inst_valid_nxt = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          kill_nxt  = 1'b0;
          state_nxt = ST_REQ;
          if (redirect_valid) begin
            pc_nxt = next_pc_c;
          end else if (!kill) begin
            inst_valid_nxt = 1'b1;
            inst_nxt       = imem_rsp_data;
            inst_pc_nxt    = pc;
            pc_nxt         = next_pc_c;
          end
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
          pc_nxt   = next_pc_c;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_nxt      = ST_REQ;
          pc_nxt         = next_pc_c;
          inst_valid_nxt = 1'b0;
        end else if (!stall) begin
          state_nxt = ST_REQ;
        end
      end
`ifdef PC_MISALIGN_CHECK_EN
      ST_FAULT: begin
        inst_valid_nxt = 1'b0;
        if (imem_rsp_valid) kill_nxt = 1'b0;
        if (redirect_valid && !misalign_c) begin
          pc_nxt       = next_pc_c;
          misalign_nxt = 1'b0;
          // a request abandoned on the way into FAULT may still answer
          state_nxt    = (kill && !imem_rsp_valid) ? ST_WAIT : ST_REQ;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase

`ifdef PC_MISALIGN_CHECK_EN
    if (misalign_c) begin
      state_nxt      = ST_FAULT;
      inst_valid_nxt = 1'b0;
      misalign_nxt   = 1'b1;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      kill       <= kill_nxt;
      inst_valid <= inst_valid_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // Sticky misalignment flag
  always_ff @(posedge clk) begin
    if (rst) fetch_misalign <= 1'b0;
    else     fetch_misalign <= misalign_nxt;
  end
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: cycle table plus hand-written corner sequences.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (RESET_PC = 0)
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        fetch_misalign;

  // second DUT (RESET_PC = FFFF_FFFC)
  logic        rst2 = 1'b1;
  logic        rv2 = 1'b0;
  logic [31:0] rpc2 = '0;
  logic        stall2 = 1'b0;
  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        ready2 = 1'b1;
  logic        rsp_valid2 = 1'b0;
  logic [31:0] rsp_data2 = '0;
  logic        inst_valid2;
  logic [31:0] inst2;
  logic [31:0] inst_pc2;
  logic [31:0] pc_plus4_2;
  logic        fetch_misalign2;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req_valid(req_valid), .imem_req_addr(req_addr),
    .imem_req_ready(ready), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
    .fetch_misalign(fetch_misalign)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .redirect_valid(rv2), .redirect_pc(rpc2),
    .stall(stall2), .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
    .imem_req_ready(ready2), .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .pc_plus4(pc_plus4_2),
    .fetch_misalign(fetch_misalign2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory model with programmable latency (>= 1 cycle)
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          cnt = 0;
  always @(posedge clk) begin
    rsp_valid <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else if (req_valid && ready) begin
      if (lat <= 1) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_word(req_addr);
      end else begin
        pend      <= 1'b1;
        pend_addr <= req_addr;
        cnt       <= lat - 1;
      end
    end else if (pend) begin
      if (cnt <= 1) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_word(pend_addr);
        pend      <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Single-cycle memory for the second DUT
  always @(posedge clk) begin
    rsp_valid2 <= req_valid2 && ready2 && !rst2;
    rsp_data2  <= mem_word(req_addr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle after the falling edge, then let comb outputs settle
  task automatic drive(input logic s, input logic rv, input logic [31:0] rp, input logic rd);
    @(negedge clk);
    stall = s; redirect_valid = rv; redirect_pc = rp; ready = rd;
    #1;
  endtask

  typedef struct {
    logic        s;
    logic        rv;
    logic [31:0] rp;
    logic        rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [16];

  initial begin
    bit seen_iv;
    bit found;

    // cycles 1..16 after reset release
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC};
    tbl[13] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst req_valid", 32'(req_valid), 32'd0);
    check("rst req_addr", req_addr, 32'h0);
    check("rst inst_valid", 32'(inst_valid), 32'd0);
    check("rst inst", inst, 32'h0);
    check("rst inst_pc", inst_pc, 32'h0);
    check("rst fetch_misalign", 32'(fetch_misalign), 32'd0);
    check("rst2 req_addr", req_addr2, 32'hFFFF_FFFC);
    rst = 1'b0;

    // sequential fetch, stall hold, redirect colliding with a response
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].rv, tbl[i].rp, tbl[i].rd);
      check($sformatf("row%0d req_valid", i), 32'(req_valid), 32'(tbl[i].e_req));
      check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_req) check($sformatf("row%0d req_addr", i), req_addr, tbl[i].e_addr);
      if (tbl[i].e_iv) begin
        check($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].e_pc);
        check($sformatf("row%0d inst", i), inst, mem_word(tbl[i].e_pc));
        check($sformatf("row%0d pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
      end
    end

    // memory not ready: request held stable, redirect retargets it
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("nr0 req_valid", 32'(req_valid), 32'd1);
    check("nr0 req_addr", req_addr, 32'h104);
    check("nr0 inst_pc", inst_pc, 32'h100);
    for (int k = 1; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      check($sformatf("nr%0d req_valid", k), 32'(req_valid), 32'd1);
      check($sformatf("nr%0d req_addr", k), req_addr, 32'h104);
    end
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    check("nr3 req_addr", req_addr, 32'h104);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir40 req_valid", 32'(req_valid), 32'd1);
    check("redir40 req_addr", req_addr, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    lat = 3;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("i40 inst_valid", 32'(inst_valid), 32'd1);
    check("i40 inst_pc", inst_pc, 32'h40);
    check("i40 req_addr", req_addr, 32'h44);

    // redirect during a slow WAIT: late response must be dropped
    drive(1'b0, 1'b1, 32'h80, 1'b1);
    check("kill req_valid", 32'(req_valid), 32'd0);
    seen_iv = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (inst_valid) seen_iv = 1'b1;
      if (req_valid) found = 1'b1;
    end
    check("kill req seen", 32'(found), 32'd1);
    check("kill no inst", 32'(seen_iv), 32'd0);
    check("kill req_addr", req_addr, 32'h80);
    lat = 1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (inst_valid) found = 1'b1;
    end
    check("i80 seen", 32'(found), 32'd1);
    check("i80 inst_pc", inst_pc, 32'h80);
    check("i80 inst", inst, mem_word(32'h80));

    // stall the presented instruction, then squash it with a redirect
    stall = 1'b1;
    #1;
    check("hold gate req_valid", 32'(req_valid), 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check("hold inst_valid", 32'(inst_valid), 32'd1);
    check("hold inst_pc", inst_pc, 32'h80);
    check("hold req_valid", 32'(req_valid), 32'd0);
    drive(1'b1, 1'b1, 32'h300, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("squash inst_valid", 32'(inst_valid), 32'd0);
    check("squash req_valid", 32'(req_valid), 32'd1);
    check("squash req_addr", req_addr, 32'h300);

    // misaligned redirect
    drive(1'b0, 1'b1, 32'h102, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PC_MISALIGN_CHECK_EN
    check("mis flag", 32'(fetch_misalign), 32'd1);
    check("mis req_valid", 32'(req_valid), 32'd0);
    check("mis inst_valid", 32'(inst_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis sticky", 32'(fetch_misalign), 32'd1);
    check("mis sticky req", 32'(req_valid), 32'd0);
    drive(1'b0, 1'b1, 32'h200, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis clear", 32'(fetch_misalign), 32'd0);
    check("mis clear req_valid", 32'(req_valid), 32'd1);
    check("mis clear req_addr", req_addr, 32'h200);
`else
    check("mask flag", 32'(fetch_misalign), 32'd0);
    check("mask req_valid", 32'(req_valid), 32'd1);
    check("mask req_addr", req_addr, 32'h100);
`endif

    // RESET_PC at the top of the address space wraps
    @(negedge clk);
    rst2 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      #1;
      if (inst_valid2) found = 1'b1;
    end
    check("wrap seen", 32'(found), 32'd1);
    check("wrap inst_pc", inst_pc2, 32'hFFFF_FFFC);
    check("wrap pc_plus4", pc_plus4_2, 32'h0);
    check("wrap req_valid", 32'(req_valid2), 32'd1);
    check("wrap req_addr", req_addr2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
